// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: states, opcodes,
// datapath select codes and ALU operation codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's alu_op class plus the
// instruction's funct fields onto a concrete ALU operation.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op[5] separates R-type sub from I-type addi, which has no sub form
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: Moore-decoded datapath
// selects and write strobes per state, with the branch-qualified PC write.
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] alu_op;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       mem_write_s;
    logic       pc_update;
    logic       branch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_REG;
        result_src  = RES_ALUOUT;
        adr_src     = 1'b0;
        alu_op      = ALUOP_ADD;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                result_src = RES_ALUOUT;
                adr_src    = 1'b1;
            end
            S_MEMWB: begin
                result_src  = RES_DATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                result_src  = RES_ALUOUT;
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_REG;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_src  = RES_ALUOUT;
                reg_write_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_REG;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so the FETCH strobes stay low while held in reset
    assign ir_write  = reset & ir_write_s;
    assign reg_write = reset & reg_write_s;
    assign mem_write = reset & mem_write_s;
    assign pc_write  = reset & (pc_update | (branch & zero));

    assign imm_src = imm_src_for(op);
    assign state   = state_q;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected outputs are queued when an
// instruction is issued and popped against the DUT on each falling edge.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] state;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .adr_src     (adr_src),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic [1:0] imm;
        logic       adr;
        logic [2:0] aluc;
        logic       irw;
        logic       pcw;
        logic       regw;
        logic       memw;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic op5, input logic f7);
        case (f3)
            3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t model(input string tag, input logic [3:0] st, input logic [6:0] o,
                                   input logic [2:0] f3, input logic f7, input logic z);
        exp_t e;
        e.tag = tag; e.st = st;
        e.sa = 2'b00; e.sb = 2'b00; e.rs = 2'b00; e.adr = 1'b0; e.aluc = 3'b000;
        e.irw = 1'b0; e.pcw = 1'b0; e.regw = 1'b0; e.memw = 1'b0;
        e.imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
                (o == 7'b1101111) ? 2'b11 : 2'b00;
        case (st)
            4'd0:  begin e.sb = 2'b10; e.rs = 2'b10; e.irw = 1'b1; e.pcw = 1'b1; end
            4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
            4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
            4'd3:  begin e.adr = 1'b1; end
            4'd4:  begin e.rs = 2'b01; e.regw = 1'b1; end
            4'd5:  begin e.adr = 1'b1; e.memw = 1'b1; end
            4'd6:  begin e.sa = 2'b10; e.aluc = funct_alu(f3, o[5], f7); end
            4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.aluc = funct_alu(f3, o[5], f7); end
            4'd8:  begin e.regw = 1'b1; end
            4'd9:  begin e.sa = 2'b10; e.aluc = 3'b001; e.pcw = z; end
            4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val({e.tag, ".state"},       32'(state),       32'(e.st));
            check_val({e.tag, ".alu_src_a"},   32'(alu_src_a),   32'(e.sa));
            check_val({e.tag, ".alu_src_b"},   32'(alu_src_b),   32'(e.sb));
            check_val({e.tag, ".result_src"},  32'(result_src),  32'(e.rs));
            check_val({e.tag, ".adr_src"},     32'(adr_src),     32'(e.adr));
            check_val({e.tag, ".imm_src"},     32'(imm_src),     32'(e.imm));
            check_val({e.tag, ".alu_control"}, 32'(alu_control), 32'(e.aluc));
            check_val({e.tag, ".ir_write"},    32'(ir_write),    32'(e.irw));
            check_val({e.tag, ".pc_write"},    32'(pc_write),    32'(e.pcw));
            check_val({e.tag, ".reg_write"},   32'(reg_write),   32'(e.regw));
            check_val({e.tag, ".mem_write"},   32'(mem_write),   32'(e.memw));
        end
    end

    // Entered at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input logic [3:0] seq [6], input int n);
        int budget;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int i = 0; i < n; i++)
            sb_q.push_back(model($sformatf("%s[%0d]", name, i), seq[i], o, f3, f7, z));
        budget = 20;
        while (sb_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (sb_q.size() != 0) begin
            check_val({name, ".timeout"}, 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        check_val("watchdog", 32'd1, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
        #2 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("rst.state",     32'(state),     32'd0);
            check_val("rst.ir_write",  32'(ir_write),  32'd0);
            check_val("rst.pc_write",  32'(pc_write),  32'd0);
            check_val("rst.reg_write", 32'(reg_write), 32'd0);
            check_val("rst.mem_write", 32'(mem_write), 32'd0);
            check_val("rst.alu_src_b", 32'(alu_src_b), 32'd2);
        end
        @(posedge clk);
        #1 reset = 1'b1;

        run_instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 5);
        run_instr("sw",      7'b0100011, 3'b010, 1'b0, 1'b0, '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}, 4);
        run_instr("sub",     7'b0110011, 3'b000, 1'b1, 1'b0, '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd0}, 4);
        run_instr("add",     7'b0110011, 3'b000, 1'b0, 1'b1, '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd0}, 4);
        run_instr("and",     7'b0110011, 3'b111, 1'b0, 1'b0, '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd0}, 4);
        run_instr("or",      7'b0110011, 3'b110, 1'b0, 1'b0, '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd0}, 4);
        run_instr("slt",     7'b0110011, 3'b010, 1'b0, 1'b0, '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd0}, 4);
        run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 4'd0}, 4);
        run_instr("xori",    7'b0010011, 3'b100, 1'b0, 1'b0, '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 4'd0}, 4);
        run_instr("beq_t",   7'b1100011, 3'b000, 1'b0, 1'b1, '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0}, 3);
        run_instr("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0}, 3);
        run_instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0, 4'd0}, 4);
        run_instr("unknown", 7'b1111111, 3'b000, 1'b0, 1'b0, '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}, 2);
        run_instr("lw2",     7'b0000011, 3'b010, 1'b0, 1'b0, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 5);

        // Abort a store in MEMWRITE with an asynchronous reset
        op = 7'b0100011; funct3 = 3'b010;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (state != 4'd5 && k < 10);
        check_val("abort.reached_memwrite", 32'(state),     32'd5);
        check_val("abort.mem_write_before", 32'(mem_write), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("abort.mem_write_after", 32'(mem_write), 32'd0);
        check_val("abort.state_after",     32'(state),     32'd0);
        check_val("abort.pc_write_after",  32'(pc_write),  32'd0);
        check_val("abort.ir_write_after",  32'(ir_write),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        run_instr("recover", 7'b0110011, 3'b000, 1'b1, 1'b0, '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd0}, 4);

        @(negedge clk);
        check_val("final.state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
